fetch_sequencer: RTL and testbench

// Program sequencer feeding control_unit: owns the PC, fetches instructions from

---
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, fetches into the IR over a req/valid handshake
// and applies decoder pc_sel/end_sig and flag enables during the single EXEC cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_FETCH | imem_req high at pc, waiting for imem_valid
// S_EXEC  | one cycle, IR presented to decoder, pc/flags updated at end
// S_HALT  | HALT executed, pc and flags frozen until start
module fetch_sequencer #(
  parameter int unsigned          ADDR_W  = 8,
  parameter int unsigned          INSTR_W = 16,
  parameter logic [ADDR_W-1:0]    RST_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic [1:0]         pc_sel,
  input  logic               end_sig,
  input  logic               z_en,
  input  logic               c_en,
  input  logic               alu_z,
  input  logic               alu_c,
  output logic [3:0]         opcode,
  output logic [INSTR_W-1:0] instr,
  output logic               z_flag,
  output logic               c_flag,
  output logic               exec_valid,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 z_q, z_d;
  logic                 c_q, c_d;

  logic [ADDR_W-1:0]    pc_inc;
  logic [ADDR_W-1:0]    target;

  assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign target = ir_q[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RST_PC;
          z_d     = 1'b0;
          c_d     = 1'b0;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (end_sig) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          // branch tests the flag as it stood entering EXEC, not this cycle's alu_z
          case (pc_sel)
            2'b01:   pc_d = target;
            2'b10:   pc_d = z_q ? target : pc_inc;
            default: pc_d = pc_inc;
          endcase
          if (z_en) z_d = alu_z;
          if (c_en) c_d = alu_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign exec_valid = (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);
  assign pc         = pc_q;
  assign instr      = ir_q;
  assign opcode     = ir_q[INSTR_W-1 -: 4];
  assign z_flag     = z_q;
  assign c_flag     = c_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: expected fetch addresses are queued
// as stimulus is planned and popped as the DUT issues each fetch.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [1:0]  pc_sel;
  logic        end_sig, z_en, c_en, alu_z, alu_c;
  logic [3:0]  opcode;
  logic [15:0] instr;
  logic        z_flag, c_flag, exec_valid, halted;
  logic [7:0]  pc;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  e;

  logic [7:0]  obs_addr;
  int          obs_req_cycles;
  logic        obs_stable;
  logic        obs_exec;
  logic        obs_req_in_exec;
  logic [15:0] obs_instr;
  logic [3:0]  obs_opcode;
  int          obs_exec_cyc;

  fetch_sequencer #(.ADDR_W(8), .INSTR_W(16), .RST_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .pc_sel(pc_sel), .end_sig(end_sig), .z_en(z_en), .c_en(c_en),
    .alu_z(alu_z), .alu_c(alu_c),
    .opcode(opcode), .instr(instr), .z_flag(z_flag), .c_flag(c_flag),
    .exec_valid(exec_valid), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // decoder/ALU inputs outside EXEC are deliberately hostile; the DUT must ignore them
  task automatic drive_junk();
    pc_sel = 2'b01; end_sig = 1'b1; z_en = 1'b1; c_en = 1'b1; alu_z = 1'b1; alu_c = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Serves one fetch with wait_n stall cycles, then drives the decoder during EXEC.
  task automatic run_instr(input int wait_n, input logic [15:0] ins, input logic [1:0] sel,
                           input logic endv, input logic ze, input logic ce,
                           input logic az, input logic ac);
    int n;
    obs_addr = 'x; obs_req_cycles = 0; obs_stable = 1'b1; obs_exec = 1'bx;
    obs_instr = 'x; obs_opcode = 'x; obs_req_in_exec = 1'bx; obs_exec_cyc = -100;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) return;
    obs_addr = imem_addr;
    for (int i = 0; i < wait_n; i++) begin
      obs_req_cycles++;
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== obs_addr) obs_stable = 1'b0;
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    obs_req_cycles++;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = ~ins;
    obs_exec = exec_valid; obs_instr = instr; obs_opcode = opcode;
    obs_req_in_exec = imem_req; obs_exec_cyc = cyc;
    pc_sel = sel; end_sig = endv; z_en = ze; c_en = ce; alu_z = az; alu_c = ac;
    @(negedge clk);
    drive_junk();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL reset_exec got=%b exp=0", exec_valid); end
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (pc !== 8'h00)        begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (instr !== 16'h0000)  begin errors++; $display("FAIL reset_ir got=%h exp=0000", instr); end
    checks++; if ({z_flag, c_flag} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {z_flag, c_flag}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    imem_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0 || exec_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_start req=%b exec=%b exp=0 0", imem_req, exec_valid);
    end
    imem_valid = 1'b0;
  endtask

  task automatic test_sequential();
    int prev;
    prev = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    do_start();
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 16'h1020 + 16'(i), 2'b00, 0, 0, 0, 0, 0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (obs_addr !== e) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, obs_addr, e); end
      checks++; if (obs_exec !== 1'b1 || obs_instr !== 16'h1020 + 16'(i)) begin
        errors++; $display("FAIL seq_exec[%0d] exec=%b ir=%h exp=1 %h", i, obs_exec, obs_instr, 16'h1020 + 16'(i));
      end
      checks++; if (obs_req_cycles != 1) begin errors++; $display("FAIL seq_req_len[%0d] got=%0d exp=1", i, obs_req_cycles); end
      if (i > 0) begin
        checks++; if (obs_exec_cyc - prev != 2) begin
          errors++; $display("FAIL seq_exec_spacing[%0d] got=%0d exp=2", i, obs_exec_cyc - prev);
        end
      end
      prev = obs_exec_cyc;
    end
  endtask

  task automatic test_wait();
    exp_q.push_back(8'h04);
    run_instr(3, 16'h1ABC, 2'b00, 0, 0, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL wait_addr got=%h exp=%h", obs_addr, e); end
    checks++; if (obs_req_cycles != 4 || obs_stable !== 1'b1) begin
      errors++; $display("FAIL wait_req_held cycles=%0d stable=%b exp=4 1", obs_req_cycles, obs_stable);
    end
    checks++; if (obs_instr !== 16'h1ABC || obs_req_in_exec !== 1'b0) begin
      errors++; $display("FAIL wait_ir_once ir=%h req=%b exp=1abc 0", obs_instr, obs_req_in_exec);
    end
  endtask

  task automatic test_jump();
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h40);
    run_instr(0, 16'h2040, 2'b01, 0, 0, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL jump_src got=%h exp=%h", obs_addr, e); end
    checks++; if (obs_opcode !== 4'h2) begin errors++; $display("FAIL jump_opcode got=%h exp=2", obs_opcode); end
    run_instr(1, 16'h1000, 2'b00, 0, 0, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL jump_dst got=%h exp=%h", obs_addr, e); end
  endtask

  task automatic test_branch();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h10);
    run_instr(0, 16'h3000, 2'b00, 0, 1, 1, 1, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL br_sub_addr got=%h exp=%h", obs_addr, e); end
    checks++; if ({z_flag, c_flag} !== 2'b11) begin errors++; $display("FAIL br_flags_set got=%b exp=11", {z_flag, c_flag}); end
    // alu_z=0 with z_en: branch must still see the held z_flag=1
    run_instr(0, 16'h4010, 2'b10, 0, 1, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL br_bz_addr got=%h exp=%h", obs_addr, e); end
    checks++; if ({z_flag, c_flag} !== 2'b01) begin errors++; $display("FAIL br_flags_upd got=%b exp=01", {z_flag, c_flag}); end
    run_instr(0, 16'h4030, 2'b10, 0, 0, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL br_taken_dst got=%h exp=%h", obs_addr, e); end
    checks++; if (pc !== 8'h11) begin errors++; $display("FAIL br_not_taken got=%h exp=11", pc); end
  endtask

  task automatic test_wrap();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    run_instr(0, 16'h20FF, 2'b01, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (obs_addr !== e) begin errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, obs_addr, e); end
      run_instr(0, 16'h1000, 2'b00, 0, 0, 0, 0, 0);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL wrap_addr[2] got=%h exp=%h", obs_addr, e); end
  endtask

  task automatic test_halt();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h07);
    run_instr(0, 16'h2007, 2'b01, 0, 0, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL halt_jsrc got=%h exp=%h", obs_addr, e); end
    run_instr(0, 16'hF033, 2'b01, 1, 1, 1, 1, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL halt_addr got=%h exp=%h", obs_addr, e); end
    repeat (3) @(negedge clk);
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL halt_state halted=%b req=%b exp=1 0", halted, imem_req);
    end
    checks++; if (pc !== 8'h07 || {z_flag, c_flag} !== 2'b01) begin
      errors++; $display("FAIL halt_frozen pc=%h flags=%b exp=07 01", pc, {z_flag, c_flag});
    end
    do_start();
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== 8'h00 || {z_flag, c_flag} !== 2'b00) begin
      errors++; $display("FAIL restart halted=%b req=%b pc=%h flags=%b exp=0 1 00 00", halted, imem_req, pc, {z_flag, c_flag});
    end
    exp_q.push_back(8'h00);
    run_instr(0, 16'h1000, 2'b00, 0, 0, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL restart_addr got=%h exp=%h", obs_addr, e); end
  endtask

  task automatic test_random();
    logic [7:0] m_pc;
    logic       m_z, m_c;
    logic [1:0] sel;
    logic [7:0] tgt;
    logic       ze, ce, az, ac;
    m_pc = 8'h01; m_z = 1'b0; m_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sel = 2'($urandom_range(0, 3));
      tgt = 8'($urandom_range(0, 255));
      ze = 1'($urandom_range(0, 1)); az = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1)); ac = 1'($urandom_range(0, 1));
      exp_q.push_back(m_pc);
      run_instr($urandom_range(0, 2), {4'h6, 4'h0, tgt}, sel, 0, ze, ce, az, ac);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (obs_addr !== e) begin errors++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, obs_addr, e); end
      if (sel == 2'b01 || (sel == 2'b10 && m_z)) m_pc = tgt;
      else m_pc = m_pc + 8'h01;
      if (ze) m_z = az;
      if (ce) m_c = ac;
      checks++; if (pc !== m_pc || z_flag !== m_z || c_flag !== m_c) begin
        errors++; $display("FAIL rnd_state[%0d] pc=%h z=%b c=%b exp=%h %b %b", i, pc, z_flag, c_flag, m_pc, m_z, m_c);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk); @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmf_pre_req got=%b exp=1", imem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || exec_valid !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL rmf_async req=%b exec=%b halted=%b exp=0 0 0", imem_req, exec_valid, halted);
    end
    checks++; if (pc !== 8'h00 || instr !== 16'h0000 || {z_flag, c_flag} !== 2'b00) begin
      errors++; $display("FAIL rmf_regs pc=%h ir=%h flags=%b exp=00 0000 00", pc, instr, {z_flag, c_flag});
    end
    imem_valid = 1'b1;
    imem_rdata = 16'h2055;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0 || exec_valid !== 1'b0 || instr !== 16'h0000) begin
      errors++; $display("FAIL rmf_late_valid req=%b exec=%b ir=%h exp=0 0 0000", imem_req, exec_valid, instr);
    end
    imem_valid = 1'b0;
    do_start();
    exp_q.push_back(8'h00);
    run_instr(0, 16'h1000, 2'b00, 0, 0, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (obs_addr !== e) begin errors++; $display("FAIL rmf_recover got=%h exp=%h", obs_addr, e); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0000;
    drive_junk();
    test_reset();
    test_sequential();
    test_wait();
    test_jump();
    test_branch();
    test_wrap();
    test_halt();
    test_random();
    test_reset_mid_fetch();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
